dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's MEM-stage load/store port; this block is the target side of that port.
- Accepts one word-sized request at a time over a valid/ready request channel.
- Performs the read or byte-masked write after a programmable wait-state delay.
- Returns the result on a valid/ready response channel.
- Sits outside the core, between the MEM stage (initiator) and on-chip SRAM storage.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; must be a power of two.
- WAIT_CYCLES, 2: wait-state cycles between request acceptance and response; 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for a store; bit i enables bits 8i+7:8i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; wait counter cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage contents are not cleared and survive reset.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture we/addr/wdata/be into request registers.
  - If WAIT_CYCLES>0: load counter with WAIT_CYCLES-1 and go to WAIT. If WAIT_CYCLES=0: perform the access and go to RESP.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When the counter is 0, perform the access and go to RESP.
- Access, performed on the edge entering RESP:
  - Word index = (addr - BASE_ADDR) >> 2.
  - Load: rsp_rdata = stored word.
  - Store: write only the enabled bytes; rsp_rdata = 0.
  - req_be=0 on a store is a legal no-op and completes with rsp_err=0.
- RESP:
  - rsp_valid=1, req_ready=0; rsp_rdata and rsp_err are held stable.
  - On rsp_ready=1: go to IDLE and drive rsp_valid=0, rsp_rdata=0, rsp_err=0 from the next cycle.
  - rsp_ready=0 stalls indefinitely with no output change.
- Latency: request accepted at edge N gives rsp_valid=1 in cycle N+1+WAIT_CYCLES. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles. A new request is never accepted in the same cycle a response is consumed.
- Error conditions, with DMEM_ERR_EN defined:
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr outside BASE_ADDR .. BASE_ADDR+DEPTH_WORDS*4-1.
  - On error: no storage write, rsp_rdata=0, rsp_err=1. Latency is unchanged.
- Reset asserted in WAIT or RESP: request abandoned and state goes to IDLE. A store not yet performed (still in WAIT) leaves memory unchanged; a store already performed is kept.
- Request-channel inputs are ignored outside IDLE.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: misaligned and out-of-range checks are active as above; rsp_err is driven.
- Undefined:
  - rsp_err is tied to 0.
  - addr[1:0] is ignored (word-aligned access).
  - Word index wraps modulo DEPTH_WORDS.
  - Every request is performed.

Test Plan:
- Reset → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- WAIT_CYCLES=2: store 32'hDEADBEEF, be=4'hF, to 0x10 at edge N → rsp_valid=1 in cycle N+3 with rsp_rdata=0. Then load 0x10 → rsp_rdata=32'hDEADBEEF.
- Store 32'h11223344, be=4'b0101, over 32'hDEADBEEF at 0x10, then load 0x10 → rsp_rdata=32'hDE22BE44.
- Hold rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata stable and req_ready=0 throughout. On rsp_ready=1 → IDLE the next cycle.
- DMEM_ERR_EN, load 0x12 and store to 0x1000 (DEPTH_WORDS=1024) → rsp_err=1, rsp_rdata=0, word 0x1000>>2 modulo depth (word 0) unchanged. Without macro, a store to 0x1000 overwrites word 0.
- Assert reset during WAIT of a store to 0x20 → IDLE asynchronously, no rsp_valid. A subsequent load of 0x20 returns the prior value.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: valid/ready request in,
// wait-state delayed word access, valid/ready response out. Optional checks: DMEM_ERR_EN.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_do_access;
    logic             w_acc_we;
    logic [31:0]      w_acc_addr;
    logic [31:0]      w_acc_wdata;
    logic [3:0]       w_acc_be;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;
    logic             w_mem_we;

    // With zero wait states the access happens on the accepting edge, so use the live inputs.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_acc_we    = i_req_we;
            w_acc_addr  = i_req_addr;
            w_acc_wdata = i_req_wdata;
            w_acc_be    = i_req_be;
        end else begin
            w_acc_we    = r_we;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_be    = r_be;
        end
    end

    assign w_off = w_acc_addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];

`ifdef DMEM_ERR_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
    // Below-base addresses wrap to huge offsets, so one unsigned compare covers both ends.
    assign w_err = (w_acc_addr[1:0] != 2'b00) || ({1'b0, w_off} >= SPAN);
`else
    logic w_unused;
    assign w_err    = 1'b0;
    assign w_unused = ^{w_off[31:IDX_W+2], w_off[1:0]};
`endif

    always_comb begin
        w_next      = r_state;
        w_do_access = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_do_access = 1'b1;
                        w_next      = S_RESP;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_do_access = 1'b1;
                    w_next      = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_req_valid) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_be    <= i_req_be;
                r_cnt   <= WAIT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_do_access) begin
                r_rdata <= (w_acc_we || w_err) ? 32'd0 : r_mem[w_idx];
                r_err   <= w_err;
            end else if (r_state == S_RESP && i_rsp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage has no reset so its contents survive a reset pulse.
    assign w_mem_we = i_reset && w_do_access && w_acc_we && !w_err;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
            end
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_dmem_responder;

    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAITC), .BASE_ADDR(32'h0)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %h with empty scoreboard", rsp_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold);
        int k;
        logic [31:0] cap;
        @(posedge clk); #1;
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk);
            k++;
        end
        chk("latency", k, WAITC);
        if (hold > 0) begin
            cap = rsp_rdata;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_rdata", rsp_rdata, cap);
                chk("stall_ready", {31'd0, req_ready}, 32'd0);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_rdata", rsp_rdata, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
        xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);
        xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 5);
        xfer(1'b1, 32'h24, 32'h0, 4'hF, 32'h0, 1'b0, 0);
        xfer(1'b1, 32'h24, 32'hAABBCCDD, 4'b1010, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h24, 32'h0, 4'h0, 32'hAA00CC00, 1'b0, 0);
        xfer(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
`ifdef DMEM_ERR_EN
        xfer(1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        xfer(1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b1, 0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);
`else
        xfer(1'b0, 32'h12, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);
        xfer(1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);
`endif

        // Reset in the middle of a store's wait states: request must vanish, memory untouched.
        xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
